// File: rtl/feature_scan_addr_gen.sv
// Frame scan address generator: walks channel, then column, then row, and emits one
// linear buffer address per beat over valid/ready, pulsing done after the last beat.
module feature_scan_addr_gen #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 640,
  parameter int CH     = 3,
  parameter int ADDR_W = 21
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_ch,
  output logic [9:0]        o_col,
  output logic [9:0]        o_row,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [1:0] CH_LAST  = 2'(CH - 1);
  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_state;
  logic                r_valid, w_valid;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [1:0]          r_ch, w_ch;
  logic [9:0]          r_col, w_col;
  logic [9:0]          r_row, w_row;
  logic                r_done, w_done;
  logic                w_clr, w_xfer, w_eol, w_eof;

  // Beat flags decode the registered indices so they line up with the beat on the bus.
  assign w_xfer = r_valid & i_out_ready;
  assign w_eol  = r_valid && (r_ch == CH_LAST) && (r_col == COL_LAST);
  assign w_eof  = w_eol && (r_row == ROW_LAST);

  always_comb begin
    w_state = r_state;
    w_valid = r_valid;
    w_addr  = r_addr;
    w_ch    = r_ch;
    w_col   = r_col;
    w_row   = r_row;
    w_done  = 1'b0;
    w_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state = S_RUN;
          w_valid = 1'b1;
          w_clr   = 1'b1;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_state = S_IDLE;
          w_valid = 1'b0;
          w_clr   = 1'b1;
        end else if (w_xfer) begin
          if (w_eof) begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_done  = 1'b1;
            w_clr   = 1'b1;
          end else begin
            w_addr = r_addr + ADDR_W'(1);
            if (r_ch == CH_LAST) begin
              w_ch = 2'd0;
              if (r_col == COL_LAST) begin
                w_col = 10'd0;
                w_row = r_row + 10'd1;
              end else begin
                w_col = r_col + 10'd1;
              end
            end else begin
              w_ch = r_ch + 2'd1;
            end
          end
        end
      end
      S_DONE: begin
        // start and abort both land in IDLE here; start must be re-presented there.
        w_state = S_IDLE;
        w_clr   = 1'b1;
      end
      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
        w_clr   = 1'b1;
      end
    endcase
    if (w_clr) begin
      w_addr = '0;
      w_ch   = '0;
      w_col  = '0;
      w_row  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_ch    <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_valid <= w_valid;
      r_addr  <= w_addr;
      r_ch    <= w_ch;
      r_col   <= w_col;
      r_row   <= w_row;
      r_done  <= w_done;
    end
  end

  assign o_out_valid = r_valid;
  assign o_addr      = r_addr;
  assign o_ch        = r_ch;
  assign o_col       = r_col;
  assign o_row       = r_row;
  assign o_eol       = w_eol;
  assign o_eof       = w_eof;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = r_done;

endmodule
